// File: rtl/bus_responder_65c02.sv
// -----------------------------------------------------------------------------
// bus_responder_65c02
//
// Memory-side target for the 65C02 core's external bus. It samples the pins
// once per clk. It decodes each bus cycle into one of four regions: vector
// bytes, the I/O window, RAM, or unmapped space. It then either returns read
// data or commits the write. I/O accesses can be stretched by pulling rdy low.
//
// Ports
//   clk          system clock
//   resb         synchronous active-low reset
//   phi2         bus phase from the core; a bus cycle starts on its rising edge
//   a            bus address
//   rwb          1 = read, 0 = write
//   wdata        write data from the core
//   sync         opcode-fetch marker
//   rdata        read data to the core (holds its last value between reads)
//   rdata_oe     rdata valid / driving
//   rdy          0 = stretch the current bus cycle
//   io_addr      I/O register offset
//   io_wdata     I/O write data
//   io_we        single-clk I/O write strobe
//   io_re        single-clk I/O read strobe (io_rdata is sampled in that clk)
//   io_rdata     I/O read data
//   fetch_count  saturating count of opcode fetches
//   bus_err      sticky flag: a cycle was aborted by an early phi2 fall
// -----------------------------------------------------------------------------
module bus_responder_65c02 #(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] IO_BASE = 16'hD000,
  parameter int          IO_AW   = 4,
  parameter int          IO_WS   = 2,
  parameter logic [15:0] NMI_VEC = 16'hE100,
  parameter logic [15:0] RES_VEC = 16'hE000,
  parameter logic [15:0] IRQ_VEC = 16'hE200
) (
  input  logic             clk,
  input  logic             resb,
  input  logic             phi2,
  input  logic [15:0]      a,
  input  logic             rwb,
  input  logic [7:0]       wdata,
  input  logic             sync,
  output logic [7:0]       rdata,
  output logic             rdata_oe,
  output logic             rdy,
  output logic [IO_AW-1:0] io_addr,
  output logic [7:0]       io_wdata,
  output logic             io_we,
  output logic             io_re,
  input  logic [7:0]       io_rdata,
  output logic [15:0]      fetch_count,
  output logic             bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_HOLD
  } state_t;

  localparam logic [1:0] R_RAM = 2'd0;
  localparam logic [1:0] R_IO  = 2'd1;
  localparam logic [1:0] R_VEC = 2'd2;
  localparam logic [1:0] R_UNM = 2'd3;

  // Decode priority: vectors win over the I/O window, which wins over RAM.
  function automatic logic [1:0] decode(input logic [15:0] addr);
    logic [1:0] r;
    if (addr >= 16'hFFFA)                              r = R_VEC;
    else if (addr[15:IO_AW] == IO_BASE[15:IO_AW])      r = R_IO;
    else if (addr[15:RAM_AW] == '0)                    r = R_RAM;
    else                                               r = R_UNM;
    return r;
  endfunction

  // Vector bytes are little-endian pairs at FFFA/B, FFFC/D, FFFE/F.
  function automatic logic [7:0] vec_byte(input logic [2:0] lo);
    logic [7:0] b;
    case (lo)
      3'd2:    b = NMI_VEC[7:0];
      3'd3:    b = NMI_VEC[15:8];
      3'd4:    b = RES_VEC[7:0];
      3'd5:    b = RES_VEC[15:8];
      3'd6:    b = IRQ_VEC[7:0];
      default: b = IRQ_VEC[15:8];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0] mem [2**RAM_AW];

  // Pin sample stage
  state_t          state_q, state_d;
  logic            phi2_s_q, phi2_d_q;
  logic [15:0]     a_s_q;
  logic            rwb_s_q, sync_s_q;
  logic [7:0]      wdata_s_q;

  // Cycle latched at the start edge
  logic [15:0]     addr_q, addr_d;
  logic            rwb_q, rwb_d;
  logic            sync_q, sync_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [1:0]      region_q, region_d;

  logic [3:0]      ws_cnt_q, ws_cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rdata_oe_q, rdata_oe_d;
  logic            rdy_q, rdy_d;
  logic [IO_AW-1:0] io_addr_q, io_addr_d;
  logic [7:0]      io_wdata_q, io_wdata_d;
  logic [15:0]     fetch_count_q, fetch_count_d;
  logic            bus_err_q, bus_err_d;

  logic            start;
  logic            mem_we;
  logic [1:0]      start_region;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rwb_d         = rwb_q;
    sync_d        = sync_q;
    wdata_d       = wdata_q;
    region_d      = region_q;
    ws_cnt_d      = ws_cnt_q;
    rdata_d       = rdata_q;
    rdata_oe_d    = rdata_oe_q;
    rdy_d         = rdy_q;
    io_addr_d     = io_addr_q;
    io_wdata_d    = io_wdata_q;
    fetch_count_d = fetch_count_q;
    bus_err_d     = bus_err_q;
    io_we         = 1'b0;
    io_re         = 1'b0;
    mem_we        = 1'b0;

    start        = phi2_s_q && !phi2_d_q;
    start_region = decode(a_s_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = a_s_q;
          rwb_d     = rwb_s_q;
          sync_d    = sync_s_q;
          region_d  = start_region;
          io_addr_d = a_s_q[IO_AW-1:0];
          if (!rwb_s_q) begin
            wdata_d    = wdata_s_q;
            io_wdata_d = wdata_s_q;
          end
          if (start_region == R_IO && IO_WS > 0) begin
            state_d  = S_WAIT;
            ws_cnt_d = 4'(IO_WS);
            rdy_d    = 1'b0;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end

      S_WAIT: begin
        if (!phi2_s_q) begin
          // phi2 fell before the access happened: abort without any strobe.
          bus_err_d  = 1'b1;
          rdy_d      = 1'b1;
          rdata_oe_d = 1'b0;
          state_d    = S_IDLE;
        end else if (ws_cnt_q == 4'd1) begin
          state_d = S_ACCESS;
          rdy_d   = 1'b1;
        end else begin
          ws_cnt_d = ws_cnt_q - 4'd1;
        end
      end

      S_ACCESS: begin
        if (!phi2_s_q) begin
          bus_err_d  = 1'b1;
          rdy_d      = 1'b1;
          rdata_oe_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_HOLD;
          if (rwb_q) begin
            rdata_oe_d = 1'b1;
            case (region_q)
              R_RAM: rdata_d = mem[addr_q[RAM_AW-1:0]];
              R_IO: begin
                io_re   = 1'b1;
                rdata_d = io_rdata;
              end
              R_VEC:   rdata_d = vec_byte(addr_q[2:0]);
              default: rdata_d = 8'hFF;
            endcase
            if (sync_q) fetch_count_d = sat_inc16(fetch_count_q);
          end else begin
            // Writes to vector or unmapped space are silently dropped.
            case (region_q)
              R_RAM:   mem_we = 1'b1;
              R_IO:    io_we  = 1'b1;
              default: ;
            endcase
          end
        end
      end

      S_HOLD: begin
        if (!phi2_s_q) begin
          rdata_oe_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!resb) begin
      state_q       <= S_IDLE;
      phi2_s_q      <= 1'b0;
      phi2_d_q      <= 1'b0;
      ws_cnt_q      <= 4'd0;
      rdata_q       <= 8'h00;
      rdata_oe_q    <= 1'b0;
      rdy_q         <= 1'b1;
      io_addr_q     <= '0;
      io_wdata_q    <= 8'h00;
      fetch_count_q <= 16'h0000;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phi2_s_q      <= phi2;
      phi2_d_q      <= phi2_s_q;
      ws_cnt_q      <= ws_cnt_d;
      rdata_q       <= rdata_d;
      rdata_oe_q    <= rdata_oe_d;
      rdy_q         <= rdy_d;
      io_addr_q     <= io_addr_d;
      io_wdata_q    <= io_wdata_d;
      fetch_count_q <= fetch_count_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Data-only registers: pin samples and the latched cycle
  always_ff @(posedge clk) begin
    a_s_q     <= a;
    rwb_s_q   <= rwb;
    sync_s_q  <= sync;
    wdata_s_q <= wdata;
    addr_q    <= addr_d;
    rwb_q     <= rwb_d;
    sync_q    <= sync_d;
    wdata_q   <= wdata_d;
    region_q  <= region_d;
  end

  // A reset landing on the ACCESS clk must not commit the write.
  always_ff @(posedge clk) begin
    if (mem_we && resb) mem[addr_q[RAM_AW-1:0]] <= wdata_q;
  end

  assign rdata       = rdata_q;
  assign rdata_oe    = rdata_oe_q;
  assign rdy         = rdy_q;
  assign io_addr     = io_addr_q;
  assign io_wdata    = io_wdata_q;
  assign fetch_count = fetch_count_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_bus_responder_65c02.sv
// -----------------------------------------------------------------------------
// tb_bus_responder_65c02
//
// Directed bench for bus_responder_65c02 with default parameters.
// Stimulus tasks drive whole bus cycles. For every read they queue the
// expected byte. A monitor compares that queue against the DUT's data each
// time rdata_oe rises.
// -----------------------------------------------------------------------------
module tb_bus_responder_65c02;

  logic        clk = 1'b0;
  logic        resb;
  logic        phi2;
  logic [15:0] a;
  logic        rwb;
  logic [7:0]  wdata;
  logic        sync;
  logic [7:0]  rdata;
  logic        rdata_oe;
  logic        rdy;
  logic [3:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_rdata;
  logic [15:0] fetch_count;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];

  // Observations from the most recent bus cycle
  int         last_lat;
  int         last_rdy_lo;
  int         last_re_cnt;
  int         last_we_cnt;
  logic [3:0] last_re_addr;
  logic [3:0] last_we_addr;
  logic [7:0] last_we_data;

  always #5 clk = ~clk;

  bus_responder_65c02 dut (
    .clk         (clk),
    .resb        (resb),
    .phi2        (phi2),
    .a           (a),
    .rwb         (rwb),
    .wdata       (wdata),
    .sync        (sync),
    .rdata       (rdata),
    .rdata_oe    (rdata_oe),
    .rdy         (rdy),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_we       (io_we),
    .io_re       (io_re),
    .io_rdata    (io_rdata),
    .fetch_count (fetch_count),
    .bus_err     (bus_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop one expected byte per rising rdata_oe.
  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (rdata_oe === 1'b1 && prev_oe === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdata_oe", 32'(rdata_oe), 32'd0);
      end else begin
        check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
    end
    if (io_we === 1'b1 || io_re === 1'b1) check("io_strobe_excl", 32'(io_we & io_re), 32'd0);
    prev_oe <= rdata_oe;
  end

  // One full bus cycle: raise phi2, hold it 8 clks, drop it, idle 3 clks.
  // n counts negedges after phi2 rises; the DUT's start edge is the first
  // posedge, so a zero-wait read shows rdata_oe at n=3 and an I/O read at n=5.
  task automatic bus_cycle(input logic [15:0] addr, input logic rw,
                           input logic [7:0] wd, input logic sy,
                           input logic [7:0] exp);
    last_lat    = 0;
    last_rdy_lo = 0;
    last_re_cnt = 0;
    last_we_cnt = 0;
    last_re_addr = 4'h0;
    last_we_addr = 4'h0;
    last_we_data = 8'h00;
    @(negedge clk);
    a = addr; rwb = rw; wdata = wd; sync = sy; phi2 = 1'b1;
    if (rw) exp_q.push_back(exp);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (rdata_oe === 1'b1 && last_lat == 0) last_lat = n;
      if (rdy === 1'b0) last_rdy_lo++;
      if (io_re === 1'b1) begin last_re_cnt++; last_re_addr = io_addr; end
      if (io_we === 1'b1) begin
        last_we_cnt++; last_we_addr = io_addr; last_we_data = io_wdata;
      end
    end
    phi2 = 1'b0;
    sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int we_seen;
    resb = 1'b0; phi2 = 1'b0; a = 16'h0000; rwb = 1'b1;
    wdata = 8'h00; sync = 1'b0; io_rdata = 8'hC3;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_rdata_oe", 32'(rdata_oe), 32'd0);
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_fetch_count", 32'(fetch_count), 32'h0000);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_strobes", 32'({io_we, io_re}), 32'd0);
    resb = 1'b1;
    repeat (2) @(negedge clk);

    // Reset vector bytes
    bus_cycle(16'hFFFC, 1'b1, 8'h00, 1'b0, 8'h00);
    check("vec_lo_latency", 32'(last_lat), 32'd3);
    check("vec_lo_rdy_lo", 32'(last_rdy_lo), 32'd0);
    bus_cycle(16'hFFFD, 1'b1, 8'h00, 1'b0, 8'hE0);
    check("vec_hi_latency", 32'(last_lat), 32'd3);
    check("vec_hi_rdy_lo", 32'(last_rdy_lo), 32'd0);

    // RAM write then opcode fetch
    bus_cycle(16'h0123, 1'b0, 8'h5A, 1'b0, 8'h00);
    check("ram_wr_no_io", 32'(last_we_cnt + last_re_cnt), 32'd0);
    bus_cycle(16'h0123, 1'b1, 8'h00, 1'b1, 8'h5A);
    check("fetch_count_1", 32'(fetch_count), 32'h0001);

    // I/O read with two wait states
    bus_cycle(16'hD003, 1'b1, 8'h00, 1'b0, 8'hC3);
    check("io_rd_rdy_lo", 32'(last_rdy_lo), 32'd2);
    check("io_rd_re_cnt", 32'(last_re_cnt), 32'd1);
    check("io_rd_addr", 32'(last_re_addr), 32'h3);
    check("io_rd_latency", 32'(last_lat), 32'd5);
    check("fetch_count_still_1", 32'(fetch_count), 32'h0001);

    // I/O write aborted by phi2 falling during WAIT
    we_seen = 0;
    @(negedge clk);
    a = 16'hD001; rwb = 1'b0; wdata = 8'h99; phi2 = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (io_we === 1'b1) we_seen++;
      if (n == 2) begin
        check("abort_rdy_in_wait", 32'(rdy), 32'd0);
        phi2 = 1'b0;
      end
      if (n == 4) begin
        check("abort_bus_err", 32'(bus_err), 32'd1);
        check("abort_rdy", 32'(rdy), 32'd1);
      end
    end
    check("abort_no_io_we", 32'(we_seen), 32'd0);
    check("abort_rdata_oe", 32'(rdata_oe), 32'd0);

    // I/O write completing normally
    bus_cycle(16'hD005, 1'b0, 8'h3C, 1'b0, 8'h00);
    check("io_wr_we_cnt", 32'(last_we_cnt), 32'd1);
    check("io_wr_addr", 32'(last_we_addr), 32'h5);
    check("io_wr_data", 32'(last_we_data), 32'h3C);
    check("io_wr_rdy_lo", 32'(last_rdy_lo), 32'd2);

    // Unmapped, vector write, other vectors
    bus_cycle(16'h8000, 1'b1, 8'h00, 1'b0, 8'hFF);
    bus_cycle(16'hFFFC, 1'b0, 8'h77, 1'b0, 8'h00);
    bus_cycle(16'hFFFC, 1'b1, 8'h00, 1'b0, 8'h00);
    bus_cycle(16'hFFFB, 1'b1, 8'h00, 1'b0, 8'hE1);
    bus_cycle(16'hFFFF, 1'b1, 8'h00, 1'b0, 8'hE2);
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    // Fetch counter saturation
    @(negedge clk);
    force dut.fetch_count_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.fetch_count_q;
    @(negedge clk);
    check("fetch_preload", 32'(fetch_count), 32'hFFFF);
    bus_cycle(16'h0123, 1'b1, 8'h00, 1'b1, 8'h5A);
    check("fetch_saturate", 32'(fetch_count), 32'hFFFF);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
